cxu_mac_responder: RTL and testbench
====================================

# cxu_mac_responder

Custom-function-unit responder for the CX interface driven by the Ibex core's `cx_*` request outputs. It is implemented in the eFPGA user fabric and returns `cx_resp_*` through the top UIO boundary. It decodes `cx_func`, executes single-cycle ALU functions or a 32-cycle shift-add multiply/MAC, and keeps four 32-bit accumulator contexts indexed by `cx_state_id`. It answers every accepted request with exactly one single-cycle response pulse.

## Interface
- `CXU_ID`, default 2'd0: ID this unit answers to.
- `clk` in 1: system clock, the same global clock as the core.
- `rst` in 1: asynchronous, active-high reset.
- `cx_rst` in 1: synchronous soft reset from the core.
- `cx_req_valid` in 1: one-cycle request strobe.
- `cx_cxu_id` in 2: target CXU.
- `cx_state_id` in 2: accumulator context select.
- `cx_virt_state_id` in 2: ignored; accepted for interface completeness.
- `cx_func` in 25: function code; only [2:0] is decoded, [24:3] is ignored.
- `cx_insn` in 32: ignored.
- `cx_req_data0` in 32: operand A.
- `cx_req_data1` in 32: operand B.
- `cx_resp_valid` out 1: one-cycle response strobe.
- `cx_resp_data` out 32: result.
- `cx_resp_status` out 4: 0 = OK, 1 = illegal function, 2 = CXU ID mismatch.
- `cx_resp_state` out 1: 1 when the selected accumulator is nonzero after the op.
- `busy` out 1: high while a multi-cycle op is in flight.

## Operation
- Function codes in `cx_func[2:0]`:
  - 0 ADD: A+B.
  - 1 POPCNT: number of ones in A (0..32).
  - 2 MUL: low 32 bits of unsigned A*B.
  - 3 MAC: acc[sid] += low32(A*B); result = new acc.
  - 4 RDACC: result = acc[sid].
  - 5 WRACC: acc[sid] = A; result = old acc.
  - 6 and 7: illegal; status 1, data 0, no state change.
- All arithmetic is modulo 2^32; there is no overflow flag.
- `cx_cxu_id` != `CXU_ID`: respond with status 2, data 0, no state change; this check takes precedence over function decode.
- FSM states:
  - IDLE: on `cx_req_valid`, latch func, sid and operands. MUL/MAC go to MULT; all other cases go to RESP.
  - MULT: 32 iterations, one multiplier bit per cycle LSB-first (add shifted A into the product when the current B bit is 1); a 5-bit counter 0..31 drives it. Move to RESP when the counter reaches 31.
  - RESP: drive `cx_resp_valid`=1 with data/status/state for one cycle, commit the accumulator write on the same edge, then return to IDLE.
- `busy` = 1 in MULT and RESP.
- A request arriving while `busy` is silently dropped; the core guarantees this does not happen.
- `cx_resp_state` reflects acc[sid] after the op. For ADD, POPCNT and MUL it reflects the current acc[sid]. For status 1 or 2 it is 0.
- `cx_rst`: clears all accumulators, aborts any in-flight op with no response, and forces IDLE.
- `cx_rst` and `cx_req_valid` in the same cycle: `cx_rst` wins and the request is dropped.

## Timing
- Reset values (`rst` high, async): state IDLE, all accumulators 0, `cx_resp_valid`=0, `cx_resp_data`=0, `cx_resp_status`=0, `cx_resp_state`=0, `busy`=0.
- All outputs are registered.
- Single-cycle ops (ADD, POPCNT, RDACC, WRACC, illegal, ID mismatch): request sampled at edge N, `cx_resp_valid` high between edges N+1 and N+2.
- MUL/MAC: request sampled at edge N, `cx_resp_valid` high between edges N+33 and N+34; `busy` high from N+1 until N+34.
- Back-to-back: a new request may be presented in the same cycle that `cx_resp_valid` is high. It is sampled at the edge that ends the response, so single-cycle ops sustain one response every 2 cycles.
- `cx_resp_data` and `cx_resp_status` hold their last values when `cx_resp_valid`=0. Checkers only sample them when `cx_resp_valid`=1.
- `rst` asserted mid-MULT: immediate return to reset values, no response.

## Test plan
- After reset, ADD A=0xFFFFFFFF B=2 -> one pulse 1 cycle later, data 0x00000001, status 0, state 0.
- POPCNT A=0xF0F0000F -> data 12; func 6 -> status 1, data 0.
- WRACC sid=1 A=5, then MAC sid=1 A=3 B=7 -> WRACC returns old value 0; MAC pulse exactly 33 cycles after its request, data 26, state 1; RDACC sid=0 -> data 0, state 0.
- MUL A=0x10000 B=0x10000 -> data 0 (wrap), 33-cycle latency. A second request issued at cycle +10 is dropped and produces no extra pulse.
- `cx_cxu_id`=1 with `CXU_ID`=0, func 0 -> status 2, data 0, accumulators unchanged.
- `cx_rst` at cycle +15 of a MAC -> no response, `busy` low next cycle, RDACC on every sid returns 0. `cx_rst` coincident with an ADD request -> no response.

Source files
------------

// File: rtl/cxu_mac_responder.sv
// CX-interface custom function unit: single-cycle ALU ops, a bit-serial shift-add
// multiplier and four 32-bit accumulator contexts selected by cx_state_id.
module cxu_mac_responder #(
  parameter logic [1:0] CXU_ID = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cx_rst,
  input  logic        cx_req_valid,
  input  logic [1:0]  cx_cxu_id,
  input  logic [1:0]  cx_state_id,
  input  logic [1:0]  cx_virt_state_id,
  input  logic [24:0] cx_func,
  input  logic [31:0] cx_insn,
  input  logic [31:0] cx_req_data0,
  input  logic [31:0] cx_req_data1,
  output logic        cx_resp_valid,
  output logic [31:0] cx_resp_data,
  output logic [3:0]  cx_resp_status,
  output logic        cx_resp_state,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMult, StResp} state_e;

  localparam logic [2:0] FnAdd    = 3'd0;
  localparam logic [2:0] FnPopcnt = 3'd1;
  localparam logic [2:0] FnMul    = 3'd2;
  localparam logic [2:0] FnMac    = 3'd3;
  localparam logic [2:0] FnRdacc  = 3'd4;
  localparam logic [2:0] FnWracc  = 3'd5;

  localparam logic [3:0] StatusOk      = 4'd0;
  localparam logic [3:0] StatusIllegal = 4'd1;
  localparam logic [3:0] StatusIdMiss  = 4'd2;

  state_e      state_q, state_d;
  logic [2:0]  func_q, func_d;
  logic [1:0]  sid_q, sid_d;
  logic        id_ok_q, id_ok_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q [4];
  logic [31:0] acc_d [4];

  logic        resp_valid_d;
  logic [31:0] resp_data_d;
  logic [3:0]  resp_status_d;
  logic        resp_state_d;
  logic        busy_d;

  logic [31:0] acc_sel;
  logic [31:0] mac_sum;

  // Interface fields this unit never decodes.
  logic unused_inputs;
  assign unused_inputs = ^{cx_virt_state_id, cx_func[24:3], cx_insn};

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  assign acc_sel = acc_q[sid_q];
  assign mac_sum = acc_sel + prod_q;

  always_comb begin
    state_d       = state_q;
    func_d        = func_q;
    sid_d         = sid_q;
    id_ok_d       = id_ok_q;
    a_d           = a_q;
    b_d           = b_q;
    prod_d        = prod_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = cx_resp_data;
    resp_status_d = cx_resp_status;
    resp_state_d  = cx_resp_state;
    // Lags the state by one cycle so it covers the response pulse as well.
    busy_d        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (cx_req_valid) begin
          func_d  = cx_func[2:0];
          sid_d   = cx_state_id;
          id_ok_d = (cx_cxu_id == CXU_ID);
          a_d     = cx_req_data0;
          b_d     = cx_req_data1;
          prod_d  = '0;
          cnt_d   = '0;
          if ((cx_cxu_id == CXU_ID) && (cx_func[2:0] == FnMul || cx_func[2:0] == FnMac)) begin
            state_d = StMult;
          end else begin
            state_d = StResp;
          end
        end
      end

      StMult: begin
        // One multiplier bit per cycle, LSB first; A shifts up as B shifts down.
        if (b_q[0]) begin
          prod_d = prod_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StResp;
        end
      end

      StResp: begin
        state_d       = StIdle;
        resp_valid_d  = 1'b1;
        resp_status_d = StatusOk;
        resp_state_d  = (acc_sel != '0);
        if (!id_ok_q) begin
          resp_status_d = StatusIdMiss;
          resp_data_d   = '0;
          resp_state_d  = 1'b0;
        end else begin
          unique case (func_q)
            FnAdd:    resp_data_d = a_q + b_q;
            FnPopcnt: resp_data_d = {26'd0, popcount(a_q)};
            FnMul:    resp_data_d = prod_q;
            FnMac: begin
              resp_data_d   = mac_sum;
              resp_state_d  = (mac_sum != '0);
              acc_d[sid_q]  = mac_sum;
            end
            FnRdacc:  resp_data_d = acc_sel;
            FnWracc: begin
              resp_data_d   = acc_sel;
              resp_state_d  = (a_q != '0);
              acc_d[sid_q]  = a_q;
            end
            default: begin
              resp_status_d = StatusIllegal;
              resp_data_d   = '0;
              resp_state_d  = 1'b0;
            end
          endcase
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      func_q         <= '0;
      sid_q          <= '0;
      id_ok_q        <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      prod_q         <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
      cx_resp_valid  <= 1'b0;
      cx_resp_data   <= '0;
      cx_resp_status <= '0;
      cx_resp_state  <= 1'b0;
      busy           <= 1'b0;
    end else if (cx_rst) begin
      // Soft reset aborts silently; response data/status keep their last values.
      state_q       <= StIdle;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
      cx_resp_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q        <= state_d;
      func_q         <= func_d;
      sid_q          <= sid_d;
      id_ok_q        <= id_ok_d;
      a_q            <= a_d;
      b_q            <= b_d;
      prod_q         <= prod_d;
      cnt_q          <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
      end
      cx_resp_valid  <= resp_valid_d;
      cx_resp_data   <= resp_data_d;
      cx_resp_status <= resp_status_d;
      cx_resp_state  <= resp_state_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_cxu_mac_responder.sv
// Scoreboard bench for cxu_mac_responder: directed requests push expected responses,
// a negedge monitor pops and checks data, status, state and pulse timing.
module tb_cxu_mac_responder;

  logic        clk;
  logic        rst;
  logic        cx_rst;
  logic        cx_req_valid;
  logic [1:0]  cx_cxu_id;
  logic [1:0]  cx_state_id;
  logic [1:0]  cx_virt_state_id;
  logic [24:0] cx_func;
  logic [31:0] cx_insn;
  logic [31:0] cx_req_data0;
  logic [31:0] cx_req_data1;
  logic        cx_resp_valid;
  logic [31:0] cx_resp_data;
  logic [3:0]  cx_resp_status;
  logic        cx_resp_state;
  logic        busy;

  cxu_mac_responder #(.CXU_ID(2'd0)) dut (
    .clk              (clk),
    .rst              (rst),
    .cx_rst           (cx_rst),
    .cx_req_valid     (cx_req_valid),
    .cx_cxu_id        (cx_cxu_id),
    .cx_state_id      (cx_state_id),
    .cx_virt_state_id (cx_virt_state_id),
    .cx_func          (cx_func),
    .cx_insn          (cx_insn),
    .cx_req_data0     (cx_req_data0),
    .cx_req_data1     (cx_req_data1),
    .cx_resp_valid    (cx_resp_valid),
    .cx_resp_data     (cx_resp_data),
    .cx_resp_status   (cx_resp_status),
    .cx_resp_state    (cx_resp_state),
    .busy             (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    logic        state;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && cx_resp_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_pulse: actual pulse data 0x%08h status %0d, required none",
                 cx_resp_data, cx_resp_status);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, ".data"}, cx_resp_data, e.data);
        check({e.name, ".status"}, {28'd0, cx_resp_status}, {28'd0, e.status});
        check({e.name, ".state"}, {31'd0, cx_resp_state}, {31'd0, e.state});
        check({e.name, ".cycle"}, cyc, e.cyc);
      end
    end
  end

  // One-cycle request; when a response is expected, queue it with its pulse cycle.
  task automatic issue(input logic [1:0] id, input logic [1:0] sid, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input bit want,
                       input logic [31:0] ed, input logic [3:0] es, input logic est,
                       input int lat, input string name);
    exp_t e;
    @(negedge clk);
    cx_cxu_id    = id;
    cx_state_id  = sid;
    cx_func      = {22'h2a5a5a, fn};
    cx_insn      = 32'hdeadbeef;
    cx_req_data0 = a;
    cx_req_data1 = b;
    cx_req_valid = 1'b1;
    if (want) begin
      e.data   = ed;
      e.status = es;
      e.state  = est;
      e.cyc    = cyc + 1 + lat;
      e.name   = name;
      q.push_back(e);
    end
    @(negedge clk);
    cx_req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    cx_rst = 1'b0;
    cx_req_valid = 1'b0;
    cx_cxu_id = '0;
    cx_state_id = '0;
    cx_virt_state_id = 2'd3;
    cx_func = '0;
    cx_insn = '0;
    cx_req_data0 = '0;
    cx_req_data1 = '0;
    repeat (3) @(negedge clk);
    check("rst.valid", {31'd0, cx_resp_valid}, 32'd0);
    check("rst.data", cx_resp_data, 32'd0);
    check("rst.status", {28'd0, cx_resp_status}, 32'd0);
    check("rst.state", {31'd0, cx_resp_state}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    issue(2'd0, 2'd0, 3'd0, 32'hffffffff, 32'd2, 1, 32'd1, 4'd0, 1'b0, 1, "add_wrap");
    drain();
    issue(2'd0, 2'd0, 3'd1, 32'hf0f0000f, 32'd0, 1, 32'd12, 4'd0, 1'b0, 1, "popcnt");
    drain();
    issue(2'd0, 2'd0, 3'd6, 32'd1, 32'd1, 1, 32'd0, 4'd1, 1'b0, 1, "illegal6");
    drain();
    issue(2'd0, 2'd1, 3'd5, 32'd5, 32'd0, 1, 32'd0, 4'd0, 1'b1, 1, "wracc1");
    drain();
    issue(2'd0, 2'd1, 3'd3, 32'd3, 32'd7, 1, 32'd26, 4'd0, 1'b1, 33, "mac1");
    drain();
    issue(2'd0, 2'd0, 3'd4, 32'd0, 32'd0, 1, 32'd0, 4'd0, 1'b0, 1, "rdacc0");
    drain();

    // Back-to-back: the read is sampled at the edge ending the write's pulse.
    issue(2'd0, 2'd2, 3'd5, 32'd9, 32'd0, 1, 32'd0, 4'd0, 1'b1, 1, "wracc2");
    issue(2'd0, 2'd2, 3'd4, 32'd0, 32'd0, 1, 32'd9, 4'd0, 1'b1, 1, "rdacc2_b2b");
    drain();

    // Multiply wrap; a request during the multiply must vanish.
    issue(2'd0, 2'd0, 3'd2, 32'h00010000, 32'h00010000, 1, 32'd0, 4'd0, 1'b0, 33, "mul_wrap");
    repeat (8) @(negedge clk);
    check("mul.busy", {31'd0, busy}, 32'd1);
    issue(2'd0, 2'd0, 3'd0, 32'd1, 32'd1, 0, 32'd0, 4'd0, 1'b0, 0, "dropped");
    drain();
    repeat (5) @(negedge clk);

    issue(2'd1, 2'd1, 3'd0, 32'd4, 32'd4, 1, 32'd0, 4'd2, 1'b0, 1, "id_miss");
    drain();
    issue(2'd0, 2'd1, 3'd4, 32'd0, 32'd0, 1, 32'd26, 4'd0, 1'b1, 1, "rdacc1_kept");
    drain();

    // Soft reset in the middle of a MAC: no response, busy drops, contexts cleared.
    issue(2'd0, 2'd1, 3'd3, 32'd2, 32'd2, 0, 32'd0, 4'd0, 1'b0, 0, "mac_abort");
    repeat (13) @(negedge clk);
    @(negedge clk);
    cx_rst = 1'b1;
    @(negedge clk);
    cx_rst = 1'b0;
    check("cxrst.busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      issue(2'd0, s[1:0], 3'd4, 32'd0, 32'd0, 1, 32'd0, 4'd0, 1'b0, 1, "rdacc_cleared");
      drain();
    end

    // Soft reset coincident with a request: the request is discarded.
    @(negedge clk);
    cx_rst = 1'b1;
    cx_cxu_id = 2'd0;
    cx_func = 25'd0;
    cx_req_data0 = 32'd8;
    cx_req_data1 = 32'd8;
    cx_req_valid = 1'b1;
    @(negedge clk);
    cx_rst = 1'b0;
    cx_req_valid = 1'b0;
    check("cxrst_req.busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    issue(2'd0, 2'd3, 3'd0, 32'd3, 32'd4, 1, 32'd7, 4'd0, 1'b0, 1, "add_final");
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
